// File: rtl/crossyroad_pkg.sv
// Shared definitions for the crossyroad game blocks.
package crossyroad_pkg;

  // Game-flow states; encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_PLAY    = 2'd1,
    ST_DYING   = 2'd2,
    ST_OVER    = 2'd3
  } game_state_t;

  localparam int unsigned SCORE_W_DEFAULT = 7;

  // 3-bit RGB colour codes used by the drawing blocks.
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Game-flow signal bundle between the flow controller and its neighbours.
interface game_flow_ctrl_if #(
  parameter int unsigned SCORE_W = crossyroad_pkg::SCORE_W_DEFAULT
);
  logic               move_btn;
  logic               frame_start;
  logic               collision;
  logic [SCORE_W-1:0] score;
  logic               game_rst;
  logic               move_req;
  logic               run_en;
  logic               chicken_vis;
  logic [1:0]         lives;
  logic [SCORE_W-1:0] high_score;
  logic [1:0]         state;

  modport slave (
    input  move_btn, frame_start, collision, score,
    output game_rst, move_req, run_en, chicken_vis, lives, high_score, state
  );

  modport master (
    output move_btn, frame_start, collision, score,
    input  game_rst, move_req, run_en, chicken_vis, lives, high_score, state
  );
endinterface

// File: rtl/btn_debounce.sv
// Button conditioning: 2-FF synchronizer, debouncer, rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronized input differs from the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else                                   cnt_d   = cnt_q + 1'b1;
    end
  end

  // Synchronizer, debounce state and previous level for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  // Pulse is taken from flops so the FSM reacts on the edge after the level rises.
  assign press = level_q & ~prev_q;
endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: lives, death animation, game-over hold, high score.
module game_flow_ctrl
  import crossyroad_pkg::*;
#(
  parameter int unsigned LIVES           = 3,
  parameter int unsigned DEATH_FRAMES    = 60,
  parameter int unsigned FLASH_FRAMES    = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SCORE_W         = SCORE_W_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  game_flow_ctrl_if.slave  bus
);
  localparam int unsigned FCW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

  logic press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.move_btn),
    .press   (press)
  );

  game_state_t        state_q, state_d;
  logic               game_rst_q, game_rst_d;
  logic               move_req_q, move_req_d;
  logic               run_en_q, run_en_d;
  logic               chicken_vis_q, chicken_vis_d;
  logic [1:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] high_score_q, high_score_d;
  logic               coll_f_q, coll_f_d;
  logic [FCW-1:0]     frame_cnt_q, frame_cnt_d;
  logic [31:0]        flash_phase;

  // Next-state and next-output logic; outputs reflect the state being entered.
  always_comb begin
    state_d       = state_q;
    game_rst_d    = game_rst_q;
    move_req_d    = 1'b0;
    run_en_d      = run_en_q;
    chicken_vis_d = chicken_vis_q;
    lives_d       = lives_q;
    high_score_d  = high_score_q;
    coll_f_d      = coll_f_q;
    frame_cnt_d   = frame_cnt_q;
    flash_phase   = '0;
    unique case (state_q)
      ST_ATTRACT: begin
        game_rst_d    = 1'b1;
        run_en_d      = 1'b0;
        chicken_vis_d = 1'b1;
        if (press) begin
          state_d    = ST_PLAY;
          lives_d    = 2'(LIVES);
          game_rst_d = 1'b0;
          run_en_d   = 1'b1;
          coll_f_d   = 1'b0;
        end
      end
      ST_PLAY: begin
        game_rst_d    = 1'b0;
        run_en_d      = 1'b1;
        chicken_vis_d = 1'b1;
        if (bus.collision) coll_f_d = 1'b1;
        if (bus.frame_start && (coll_f_q || bus.collision)) begin
          // Death wins over a same-cycle press.
          coll_f_d    = 1'b0;
          state_d     = ST_DYING;
          frame_cnt_d = '0;
          run_en_d    = 1'b0;
        end else begin
          if (bus.frame_start) coll_f_d = 1'b0;
          if (press) move_req_d = 1'b1;
        end
      end
      ST_DYING: begin
        game_rst_d = 1'b0;
        run_en_d   = 1'b0;
        coll_f_d   = 1'b0;
        if (bus.frame_start) begin
          if (frame_cnt_q == FCW'(DEATH_FRAMES - 1)) begin
            if (bus.score > high_score_q) high_score_d = bus.score;
            chicken_vis_d = 1'b1;
            if (lives_q > 2'd1) begin
              lives_d    = lives_q - 2'd1;
              game_rst_d = 1'b1;
              run_en_d   = 1'b1;
              state_d    = ST_PLAY;
            end else begin
              lives_d = 2'd0;
              state_d = ST_OVER;
            end
          end else begin
            frame_cnt_d   = frame_cnt_q + 1'b1;
            flash_phase   = 32'(frame_cnt_d) / 32'(FLASH_FRAMES);
            chicken_vis_d = ~flash_phase[0];
          end
        end
      end
      ST_OVER: begin
        game_rst_d    = 1'b0;
        run_en_d      = 1'b0;
        chicken_vis_d = 1'b1;
        if (press) begin
          state_d    = ST_ATTRACT;
          game_rst_d = 1'b1;
        end
      end
      default: state_d = ST_ATTRACT;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ATTRACT;
      game_rst_q    <= 1'b1;
      move_req_q    <= 1'b0;
      run_en_q      <= 1'b0;
      chicken_vis_q <= 1'b1;
      lives_q       <= 2'(LIVES);
      high_score_q  <= '0;
      coll_f_q      <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      game_rst_q    <= game_rst_d;
      move_req_q    <= move_req_d;
      run_en_q      <= run_en_d;
      chicken_vis_q <= chicken_vis_d;
      lives_q       <= lives_d;
      high_score_q  <= high_score_d;
      coll_f_q      <= coll_f_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.game_rst    = game_rst_q;
  assign bus.move_req    = move_req_q;
  assign bus.run_en      = run_en_q;
  assign bus.chicken_vis = chicken_vis_q;
  assign bus.lives       = lives_q;
  assign bus.high_score  = high_score_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl; frame_start every 20 cycles.
module tb_game_flow_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  int unsigned phase = 0;
  int mr_cnt = 0;

  always #5 clk = ~clk;

  game_flow_ctrl_if #(.SCORE_W(7)) bus ();

  game_flow_ctrl #(
    .LIVES(2), .DEATH_FRAMES(4), .FLASH_FRAMES(2), .DEBOUNCE_CYCLES(4), .SCORE_W(7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // One clock; inputs for the next edge are set 1 time unit after this edge.
  task automatic tick();
    @(posedge clk);
    #1;
    phase = (phase == 19) ? 0 : phase + 1;
    bus.frame_start = (phase == 19);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.move_req === 1'b1) mr_cnt++;
    end
  endtask

  task automatic wait_phase(input int unsigned p);
    while (phase != p) tick_n(1);
  endtask

  task automatic die();
    wait_phase(14);
    bus.collision = 1'b1;
    tick_n(1);
    bus.collision = 1'b0;
    wait_phase(0);
  endtask

  task automatic wait_exit();
    for (int i = 0; i < 200 && bus.state == 2'd2; i++) tick_n(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick_n(3);
    reset = 1'b0;
    tick_n(1);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    checks++; if (bus.game_rst !== 1'b1) begin errors++; $display("FAIL reset_game_rst: got %b want 1", bus.game_rst); end
    checks++; if (bus.lives !== 2'd2) begin errors++; $display("FAIL reset_lives: got %0d want 2", bus.lives); end
    checks++; if (bus.high_score !== 7'd0) begin errors++; $display("FAIL reset_high: got %0d want 0", bus.high_score); end
    checks++; if (bus.run_en !== 1'b0 || bus.chicken_vis !== 1'b1 || bus.move_req !== 1'b0) begin
      errors++; $display("FAIL reset_outs: run_en=%b vis=%b mr=%b want 0,1,0", bus.run_en, bus.chicken_vis, bus.move_req); end
  endtask

  task automatic test_glitch();
    mr_cnt = 0;
    bus.move_btn = 1'b1;
    tick_n(2);
    bus.move_btn = 1'b0;
    tick_n(12);
    checks++; if (bus.state !== 2'd0 || mr_cnt != 0) begin
      errors++; $display("FAIL glitch: state=%0d mr=%0d want 0,0", bus.state, mr_cnt); end
  endtask

  task automatic test_start_and_move();
    mr_cnt = 0;
    bus.move_btn = 1'b1;
    tick_n(6);
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL start_early: got %0d want 0", bus.state); end
    tick_n(1);
    checks++; if (bus.state !== 2'd1 || bus.game_rst !== 1'b0 || bus.run_en !== 1'b1) begin
      errors++; $display("FAIL start_edge: state=%0d rst=%b run=%b want 1,0,1", bus.state, bus.game_rst, bus.run_en); end
    tick_n(3);
    bus.move_btn = 1'b0;
    tick_n(10);
    checks++; if (mr_cnt != 0) begin errors++; $display("FAIL start_no_move: got %0d want 0", mr_cnt); end
    mr_cnt = 0;
    bus.move_btn = 1'b1;
    tick_n(10);
    bus.move_btn = 1'b0;
    tick_n(10);
    checks++; if (mr_cnt != 1 || bus.state !== 2'd1) begin
      errors++; $display("FAIL move_pulse: pulses=%0d state=%0d want 1,1", mr_cnt, bus.state); end
  endtask

  task automatic test_death_flash();
    logic [3:0] exp_vis;
    exp_vis = 4'b0011;
    wait_phase(14);
    bus.collision = 1'b1;
    tick_n(1);
    bus.collision = 1'b0;
    wait_phase(19);
    checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL death_pre: got %0d want 1", bus.state); end
    tick_n(1);
    checks++; if (bus.state !== 2'd2 || bus.run_en !== 1'b0) begin
      errors++; $display("FAIL death_enter: state=%0d run=%b want 2,0", bus.state, bus.run_en); end
    for (int f = 0; f < 4; f++) begin
      if (f != 0) begin tick_n(1); wait_phase(0); end
      wait_phase(10);
      checks++; if (bus.chicken_vis !== exp_vis[f]) begin
        errors++; $display("FAIL flash_%0d: got %b want %b", f, bus.chicken_vis, exp_vis[f]); end
    end
    wait_phase(0);
    checks++; if (bus.state !== 2'd1 || bus.game_rst !== 1'b1 || bus.lives !== 2'd1) begin
      errors++; $display("FAIL respawn: state=%0d rst=%b lives=%0d want 1,1,1", bus.state, bus.game_rst, bus.lives); end
    tick_n(1);
    checks++; if (bus.game_rst !== 1'b0) begin errors++; $display("FAIL respawn_rst_width: got %b want 0", bus.game_rst); end
  endtask

  task automatic test_coll_press_same_cycle();
    mr_cnt = 0;
    wait_phase(13);
    bus.move_btn = 1'b1;
    tick_n(6);
    bus.collision = 1'b1;
    tick_n(1);
    bus.collision = 1'b0;
    checks++; if (bus.state !== 2'd2 || bus.move_req !== 1'b0) begin
      errors++; $display("FAIL coll_press: state=%0d mr=%b want 2,0", bus.state, bus.move_req); end
    tick_n(3);
    bus.move_btn = 1'b0;
    tick_n(10);
    mr_cnt = 0;
    bus.move_btn = 1'b1;
    tick_n(10);
    bus.move_btn = 1'b0;
    tick_n(10);
    checks++; if (bus.state !== 2'd2 || mr_cnt != 0) begin
      errors++; $display("FAIL dying_press: state=%0d mr=%0d want 2,0", bus.state, mr_cnt); end
  endtask

  task automatic test_game_over();
    bus.score = 7'd37;
    wait_exit();
    checks++; if (bus.state !== 2'd3 || bus.lives !== 2'd0) begin
      errors++; $display("FAIL over_enter: state=%0d lives=%0d want 3,0", bus.state, bus.lives); end
    checks++; if (bus.high_score !== 7'd37) begin errors++; $display("FAIL over_high: got %0d want 37", bus.high_score); end
    tick_n(5);
    checks++; if (bus.game_rst !== 1'b0 || bus.run_en !== 1'b0 || bus.state !== 2'd3) begin
      errors++; $display("FAIL over_hold: rst=%b run=%b state=%0d want 0,0,3", bus.game_rst, bus.run_en, bus.state); end
    bus.move_btn = 1'b1;
    tick_n(7);
    checks++; if (bus.state !== 2'd0 || bus.game_rst !== 1'b1) begin
      errors++; $display("FAIL over_exit: state=%0d rst=%b want 0,1", bus.state, bus.game_rst); end
    tick_n(3);
    bus.move_btn = 1'b0;
    tick_n(10);
  endtask

  task automatic test_high_score_hold();
    bus.move_btn = 1'b1;
    tick_n(7);
    checks++; if (bus.state !== 2'd1 || bus.lives !== 2'd2) begin
      errors++; $display("FAIL restart: state=%0d lives=%0d want 1,2", bus.state, bus.lives); end
    tick_n(3);
    bus.move_btn = 1'b0;
    tick_n(10);
    bus.score = 7'd12;
    die();
    checks++; if (bus.state !== 2'd2) begin errors++; $display("FAIL hs_die: got %0d want 2", bus.state); end
    wait_exit();
    checks++; if (bus.state !== 2'd1 || bus.lives !== 2'd1 || bus.high_score !== 7'd37) begin
      errors++; $display("FAIL hs_keep: state=%0d lives=%0d high=%0d want 1,1,37", bus.state, bus.lives, bus.high_score); end
  endtask

  task automatic test_reset_mid_dying();
    die();
    tick_n(1); wait_phase(0);
    tick_n(1); wait_phase(0);
    wait_phase(10);
    checks++; if (bus.state !== 2'd2 || bus.chicken_vis !== 1'b0) begin
      errors++; $display("FAIL mid_dying: state=%0d vis=%b want 2,0", bus.state, bus.chicken_vis); end
    reset = 1'b1;
    tick_n(1);
    checks++; if (bus.state !== 2'd0 || bus.lives !== 2'd2 || bus.high_score !== 7'd0) begin
      errors++; $display("FAIL mid_reset: state=%0d lives=%0d high=%0d want 0,2,0", bus.state, bus.lives, bus.high_score); end
    checks++; if (bus.chicken_vis !== 1'b1 || bus.game_rst !== 1'b1) begin
      errors++; $display("FAIL mid_reset_outs: vis=%b rst=%b want 1,1", bus.chicken_vis, bus.game_rst); end
    reset = 1'b0;
    tick_n(2);
  endtask

  initial begin
    bus.move_btn    = 1'b0;
    bus.frame_start = 1'b0;
    bus.collision   = 1'b0;
    bus.score       = 7'd0;
    test_reset();
    test_glitch();
    test_start_and_move();
    test_death_flash();
    test_coll_press_same_cycle();
    test_game_over();
    test_high_score_hold();
    test_reset_mid_dying();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Game-flow sequencer for the crossyroad VGA game.
- Sits between the button, the pixel-level collision detect and the scroll/score blocks; replaces the direct "manual reset OR collision" reset path.
- Owns button conditioning, lives, the death animation timing, game-over hold and the high score.
- Drives the reset and enables that sequence scroll_v/scroll_h and followers, score, and chicken drawing.

Parameters:
- LIVES, 3: lives at game start (1..3).
- DEATH_FRAMES, 60: frames spent in DYING.
- FLASH_FRAMES, 8: frames per chicken on/off phase in DYING.
- DEBOUNCE_CYCLES, 250000: cycles button must be stable to change the debounced level.
- SCORE_W, 7: score width.

Ports:
- clk  in  1  system (pixel) clock
- reset  in  1  synchronous, active-high; the only clock and reset
- move_btn  in  1  raw asynchronous button
- frame_start  in  1  one-cycle pulse at hpos==0 && vpos==0
- collision  in  1  obstacle-overlaps-chicken, pixel-level, any cycle
- score  in  SCORE_W  current score from scroll_v
- game_rst  out  1  reset to scroll/score blocks
- move_req  out  1  one-cycle move pulse to scroll_v
- run_en  out  1  obstacles allowed to move
- chicken_vis  out  1  chicken drawn when 1
- lives  out  2  remaining lives
- high_score  out  SCORE_W  best score since reset
- state  out  2  ATTRACT=0, PLAY=1, DYING=2, OVER=3

Behaviour:
- Reset values (sync, next edge, from any state): state=ATTRACT, game_rst=1, move_req=0, run_en=0, chicken_vis=1, lives=LIVES, high_score=0. Frame counter, collision flag and debouncer are cleared; debounced level=0.
- Button path: 2-FF synchronizer, then debouncer. The debounced level toggles only after DEBOUNCE_CYCLES consecutive cycles at the new sampled value. "press" is a one-cycle pulse on the debounced rising edge. Holding the button gives one press. Latency from raw edge to press is 2+DEBOUNCE_CYCLES+1 cycles.
- ATTRACT:
  - game_rst=1, run_en=0.
  - press -> PLAY, lives=LIVES. game_rst falls on that same edge.
  - That press does not produce move_req.
- PLAY:
  - game_rst=0, run_en=1, chicken_vis=1.
  - press -> move_req=1 for exactly one cycle.
  - Sticky flag coll_f is set by collision.
  - On frame_start, hit = coll_f|collision and coll_f clears. If hit: -> DYING with frame_cnt=0, and any press in that cycle is dropped (no move_req).
  - At most one death per frame.
- DYING:
  - run_en=0, presses ignored, collision ignored.
  - frame_cnt increments on each frame_start.
  - chicken_vis = ((frame_cnt / FLASH_FRAMES) even), so it is 1 for the first FLASH_FRAMES frames.
  - When frame_cnt reaches DEATH_FRAMES-1 and frame_start arrives:
    - high_score = max(high_score, score), registered on that edge.
    - If lives>1: lives-1, game_rst=1 for exactly one cycle, -> PLAY.
    - Else: lives=0, -> OVER, game_rst stays 0 so the final screen and score persist.
- OVER:
  - run_en=0, chicken_vis=1.
  - press -> ATTRACT; game_rst asserts on that edge.
- high_score updates only at a DYING exit, never decreases, and clears only on reset.
- Width rules: frame_cnt is $clog2(DEATH_FRAMES) bits and never wraps within DYING. The comparison is unsigned SCORE_W.
- All outputs are registered, including move_req and game_rst.

Decomposition:
- Shared package crossyroad_pkg holds:
  - state encoding constants ST_ATTRACT/ST_PLAY/ST_DYING/ST_OVER
  - SCORE_W default
  - colour constants (RED, GREEN, BLUE)
- One sub-module, btn_debounce: synchronizer, debouncer and rising-edge pulse, parameter DEBOUNCE_CYCLES, ports clk/reset/btn_raw/press.

Test Plan (sim params: LIVES=2, DEATH_FRAMES=4, FLASH_FRAMES=2, DEBOUNCE_CYCLES=4, frame_start every 20 cycles):
- Reset held 3 cycles, then released -> state=0, game_rst=1, lives=2, high_score=0. A 2-cycle button glitch -> no state change.
- Clean press (held 10 cycles) in ATTRACT -> state=1 with game_rst=0 exactly 7 cycles after the raw edge, no move_req. A second press -> exactly one move_req pulse.
- In PLAY, a collision pulse 5 cycles before frame_start -> DYING on the frame_start edge, run_en=0. chicken_vis over 4 frames = 1,1,0,0. Then one-cycle game_rst, lives=1, state=1.
- Collision and press in the same cycle as frame_start -> DYING, move_req stays 0. A press during DYING -> no effect.
- Second death with score=37 -> high_score=37, lives=0, state=3, game_rst=0. Press -> state=0, game_rst=1. A later game dying at score=12 -> high_score stays 37.
- Reset asserted mid-DYING -> next edge state=0, lives=2, high_score=0, chicken_vis=1.
